// File: rtl/pc_gen_if.sv
// pc_gen_if: bundles the control-side and fetch-side signals of the PC generator.
//
// Build option: none.
//
// Signals
//   stall                    control -> pc_gen  stall vector, bit 0 = PC stage
//   flush                    control -> pc_gen  redirect to new_pc
//   new_pc                   control -> pc_gen  flush redirect target
//   branch_flag_i            ID      -> pc_gen  branch taken
//   branch_target_address_i  ID      -> pc_gen  branch target
//   pc                       pc_gen  -> IMEM    fetch address
//   ce                       pc_gen  -> IMEM    instruction memory enable
//   pend_valid_o             pc_gen  -> any     a deferred branch is held
//   misaligned_o             pc_gen  -> any     current pc is not INST_BYTES aligned
//
// Modports
//   master : the driving side (control / ID stage / testbench)
//   slave  : the PC generator itself
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               pend_valid_o;
    logic               misaligned_o;

    modport master (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, pend_valid_o, misaligned_o
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, pend_valid_o, misaligned_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator.
//
// Produces the fetch address and instruction-memory enable. Flush redirects
// win over everything; a branch seen while the PC stage is stalled is parked
// and applied on the first unstalled edge unless a newer live branch arrives.
//
// Build option: PC_ALIGN_CHECK_EN -- when defined, every pc load (flush,
// branch, pending branch) sets misaligned_o from the low log2(INST_BYTES)
// bits of the loaded address; sequential increments keep the flag. When
// undefined, misaligned_o is tied low.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_gen_if.slave (stall, flush, new_pc, branch_flag_i,
//          branch_target_address_i in; pc, ce, pend_valid_o, misaligned_o out)
module pc_gen #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                INST_BYTES   = 4,
    parameter int                STALL_W      = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;

    // Only the PC-stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^bus.stall;

    always_comb begin
        pc_d          = pc_q;
        ce_d          = ce_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (!ce_q) begin
            // First edge out of reset only enables fetch; RESET_VECTOR is fetched first.
            ce_d = 1'b1;
        end else if (bus.flush) begin
            pc_d         = bus.new_pc;
            pend_valid_d = 1'b0;
        end else if (bus.stall[0]) begin
            if (bus.branch_flag_i) begin
                pend_target_d = bus.branch_target_address_i;
                pend_valid_d  = 1'b1;
            end
        end else if (bus.branch_flag_i) begin
            // A live branch on the release edge supersedes any parked one.
            pc_d         = bus.branch_target_address_i;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            ce_q          <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ce_q          <= ce_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    logic misaligned_q, misaligned_d;
    logic pc_load;

    // Any non-sequential pc update; increments leave the flag untouched.
    assign pc_load = ce_q & (bus.flush |
                     (~bus.stall[0] & (bus.branch_flag_i | pend_valid_q)));
    assign misaligned_d = pc_load ? (|(pc_d & ALIGN_MASK)) : misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.misaligned_o = misaligned_q;
`else
    assign bus.misaligned_o = 1'b0;
`endif

    assign bus.pc           = pc_q;
    assign bus.ce           = ce_q;
    assign bus.pend_valid_o = pend_valid_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus randomized bench for pc_gen against a behavioural model.
module tb_pc_gen;
    localparam int          ADDR_W     = 32;
    localparam int          STALL_W    = 6;
    localparam int          INST_BYTES = 4;
    localparam logic [31:0] RV         = 32'h0;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus_if ();

    pc_gen #(
        .ADDR_W(ADDR_W), .RESET_VECTOR(RV), .INST_BYTES(INST_BYTES), .STALL_W(STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Behavioural model: the parked branch is a queue holding at most one target.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_mis;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_pc  = RV;
        m_ce  = 1'b0;
        m_mis = 1'b0;
        m_pend.delete();
    endtask

    function automatic logic unaligned(input logic [31:0] a);
        return (a % INST_BYTES) != 0;
    endfunction

    task automatic model_edge(input logic [5:0] st, input logic fl, input logic [31:0] np,
                              input logic br, input logic [31:0] tg);
        if (!m_ce) begin
            m_ce = 1'b1;
        end else if (fl) begin
            m_pc = np; m_mis = unaligned(np); m_pend.delete();
        end else if (st[0]) begin
            if (br) begin
                m_pend.delete();
                m_pend.push_back(tg);
            end
        end else if (br) begin
            m_pc = tg; m_mis = unaligned(tg); m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front(); m_mis = unaligned(m_pc);
        end else begin
            m_pc = m_pc + INST_BYTES;
        end
    endtask

    function automatic logic exp_mis();
`ifdef PC_ALIGN_CHECK_EN
        return m_mis;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/pc"}, bus_if.pc, m_pc);
        check({tag, "/ce"}, 32'(bus_if.ce), 32'(m_ce));
        check({tag, "/pend"}, 32'(bus_if.pend_valid_o), 32'(m_pend.size() != 0));
        check({tag, "/mis"}, 32'(bus_if.misaligned_o), 32'(exp_mis()));
    endtask

    task automatic step(input logic [5:0] st, input logic fl, input logic [31:0] np,
                        input logic br, input logic [31:0] tg, input string tag);
        @(negedge clk);
        bus_if.stall                   = st;
        bus_if.flush                   = fl;
        bus_if.new_pc                  = np;
        bus_if.branch_flag_i           = br;
        bus_if.branch_target_address_i = tg;
        @(posedge clk);
        model_edge(st, fl, np, br, tg);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(3, 0) != 0) a = a & 32'hFFFF_FFFC;
        return a;
    endfunction

    initial begin
        rst                            = 1'b1;
        bus_if.stall                   = '0;
        bus_if.flush                   = 1'b0;
        bus_if.new_pc                  = '0;
        bus_if.branch_flag_i           = 1'b0;
        bus_if.branch_target_address_i = '0;
        model_reset();

        #100;
        check_all("reset");
        #95 rst = 1'b0;
        @(posedge clk);
        model_edge('0, 1'b0, '0, 1'b0, '0);
        #1;
        check_all("first_edge");
        step(6'b000000, 0, 0, 0, 0, "seq4");
        step(6'b000000, 0, 0, 0, 0, "seq8");

        // stall + branch held, then released
        step(6'b000111, 0, 0, 1, 32'h10, "stall_br1");
        step(6'b000111, 0, 0, 1, 32'h10, "stall_br2");
        step(6'b000000, 0, 0, 0, 0, "pend_apply");
        step(6'b000000, 0, 0, 0, 0, "after_pend");

        // pending overwritten within a stall, then live branch overrides it
        step(6'b000001, 0, 0, 1, 32'h40, "pend_first");
        step(6'b000001, 0, 0, 1, 32'h10, "pend_overwrite");
        step(6'b000000, 0, 0, 1, 32'h1000, "live_override");
        step(6'b000000, 0, 0, 0, 0, "after_override");

        // flush beats stall and branch
        step(6'b000001, 1, 32'h180, 1, 32'h20, "flush_prio");
        step(6'b000000, 0, 0, 0, 0, "after_flush");

        // upper stall bits have no effect
        step(6'b111110, 0, 0, 0, 0, "upper_stall");

        // wrap at the top of the address space
        step(6'b000000, 0, 0, 1, 32'hFFFF_FFFC, "br_top");
        step(6'b000000, 0, 0, 0, 0, "wrap");

        // alignment flag behaviour
        step(6'b000000, 0, 0, 1, 32'h102, "br_unaligned");
        step(6'b000000, 0, 0, 0, 0, "seq_unaligned");
        step(6'b000000, 0, 0, 1, 32'h200, "br_aligned");
        step(6'b000001, 0, 0, 1, 32'h303, "pend_unaligned");
        step(6'b000000, 0, 0, 0, 0, "pend_unaligned_apply");
        step(6'b000000, 1, 32'h401, 0, 0, "flush_unaligned");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  st;
            logic        fl, br;
            logic [31:0] np, tg;
            st = 6'($urandom);
            st[0] = ($urandom_range(99, 0) < 35);
            fl = ($urandom_range(99, 0) < 6);
            br = ($urandom_range(99, 0) < 30);
            np = rand_addr();
            tg = rand_addr();
            step(st, fl, np, br, tg, "rand");
        end

        // asynchronous reset mid-cycle drops a parked branch
        step(6'b000001, 0, 0, 1, 32'h800, "pre_rst_pend");
        @(negedge clk);
        bus_if.stall         = '0;
        bus_if.branch_flag_i = 1'b0;
        bus_if.flush         = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge('0, 1'b0, '0, 1'b0, '0);
        #1;
        check_all("rst_first_edge");
        step(6'b000000, 0, 0, 0, 0, "rst_seq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
